// File: rtl/syscall_controller.sv
// syscall_controller: runs MIPS syscalls (print_int/string/char, exit) and stalls the core.
// Build option SYSCALL_STRLEN_LIMIT_EN adds a print_string byte limit and str_err.
module syscall_controller #(
  parameter int MAX_STR_LEN = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        syscall,
  input  logic [31:0] v0,
  input  logic [31:0] a0,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        out_valid,
  output logic [7:0]  out_char,
  input  logic        out_ready,
  output logic        stall,
`ifdef SYSCALL_STRLEN_LIMIT_EN
  output logic        halt,
  output logic        str_err
`else
  output logic        halt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DISPATCH,
    S_HEX,
    S_STR_REQ,
    S_STR_OUT,
    S_HALTED
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_code;
  logic [31:0] r_arg;
  logic [31:0] r_ptr;
  logic [2:0]  r_digit;
  logic [7:0]  r_char;
  logic        r_single;

  logic        w_accept;
  logic        w_str_step;
  logic        w_limit;
  logic [3:0]  w_nib;
  logic [7:0]  w_hex;

  assign w_accept   = (r_state == S_IDLE) && syscall;
  assign w_str_step = (r_state == S_STR_OUT) && out_ready && !r_single;

  // digit 0 is the most significant nibble
  assign w_nib = r_arg[{~r_digit, 2'b00} +: 4];
  assign w_hex = (w_nib < 4'd10) ? (8'h30 + {4'h0, w_nib})
                                 : (8'h57 + {4'h0, w_nib});

`ifdef SYSCALL_STRLEN_LIMIT_EN
  logic [31:0] r_cnt;
  logic        r_str_err;

  assign w_limit = (r_cnt + 32'd1) == 32'(MAX_STR_LEN);
  assign str_err = r_str_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_str_err <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (w_str_step) begin
      r_cnt <= r_cnt + 32'd1;
      if (w_limit) r_str_err <= 1'b1;
    end
  end
`else
  logic w_unused_len;
  assign w_unused_len = ^MAX_STR_LEN;
  assign w_limit      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    mem_req   = 1'b0;
    mem_addr  = '0;
    out_valid = 1'b0;
    out_char  = '0;
    halt      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (syscall) w_next = S_DISPATCH;
      end
      S_DISPATCH: begin
        case (r_code)
          32'd1:   w_next = S_HEX;
          32'd4:   w_next = S_STR_REQ;
          32'd11:  w_next = S_STR_OUT;
          32'd10:  w_next = S_HALTED;
          default: w_next = S_IDLE;
        endcase
      end
      S_HEX: begin
        out_valid = 1'b1;
        out_char  = w_hex;
        if (out_ready && r_digit == 3'd7) w_next = S_IDLE;
      end
      S_STR_REQ: begin
        mem_req  = 1'b1;
        mem_addr = r_ptr;
        if (mem_ack) begin
          if (mem_rdata == 8'h00) w_next = S_IDLE;
          else                    w_next = S_STR_OUT;
        end
      end
      S_STR_OUT: begin
        out_valid = 1'b1;
        out_char  = r_char;
        if (out_ready) begin
          if (r_single || w_limit) w_next = S_IDLE;
          else                     w_next = S_STR_REQ;
        end
      end
      S_HALTED: begin
        halt   = 1'b1;
        w_next = S_HALTED;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // high in the accepting cycle so the syscall itself is frozen in execute
  assign stall = w_accept || (r_state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_code   <= '0;
      r_arg    <= '0;
      r_ptr    <= '0;
      r_digit  <= '0;
      r_char   <= '0;
      r_single <= 1'b0;
    end else begin
      if (w_accept) begin
        r_code   <= v0;
        r_arg    <= a0;
        r_ptr    <= a0;
        r_digit  <= '0;
        r_single <= 1'b0;
      end
      if (r_state == S_DISPATCH && r_code == 32'd11) begin
        r_char   <= r_arg[7:0];
        r_single <= 1'b1;
      end
      if (r_state == S_HEX && out_ready)
        r_digit <= r_digit + 3'd1;
      if (r_state == S_STR_REQ && mem_ack && mem_rdata != 8'h00)
        r_char <= mem_rdata;
      if (w_str_step)
        r_ptr <= r_ptr + 32'd1;
    end
  end

endmodule

// File: tb/tb_syscall_controller.sv
// tb_syscall_controller: table of syscalls plus hand sequences, checked
// through a character scoreboard and a byte-memory model.
module tb_syscall_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        syscall = 1'b0;
  logic [31:0] v0 = '0;
  logic [31:0] a0 = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic        out_valid;
  logic [7:0]  out_char;
  logic        out_ready = 1'b1;
  logic        stall;
  logic        halt;
`ifdef SYSCALL_STRLEN_LIMIT_EN
  logic        str_err;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

`ifdef SYSCALL_STRLEN_LIMIT_EN
  syscall_controller #(.MAX_STR_LEN(4)) dut (
`else
  syscall_controller dut (
`endif
    .clk(clk), .reset(reset), .syscall(syscall),
    .v0(v0), .a0(a0),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_char(out_char),
    .out_ready(out_ready), .stall(stall),
`ifdef SYSCALL_STRLEN_LIMIT_EN
    .halt(halt), .str_err(str_err)
`else
    .halt(halt)
`endif
  );

  logic [7:0]  mem [0:511];
  logic [7:0]  exp_q [$];
  logic [31:0] addr_log [$];
  int          mem_lat = 0;
  int          wcnt = 0;
  logic        tog = 1'b0;
  int          stall_cnt = 0;
  int          memreq_cnt = 0;
  int          n_xfer = 0;
  logic        hold_pend = 1'b0;
  logic [7:0]  hold_ch = '0;
  logic [7:0]  exp_ch;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // console and memory responders, driven just after each edge
  always @(posedge clk) begin
    #1;
    out_ready = tog ? !out_ready : 1'b1;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    if (mem_req) begin
      if (wcnt >= mem_lat) begin
        mem_ack   = 1'b1;
        mem_rdata = mem[mem_addr[8:0]];
        addr_log.push_back(mem_addr);
        wcnt = 0;
      end else begin
        wcnt++;
      end
    end else begin
      wcnt = 0;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      hold_pend = 1'b0;
    end else begin
      if (stall) stall_cnt++;
      if (mem_req) memreq_cnt++;
      if (hold_pend && out_valid) check("hold_char", out_char, hold_ch);
      if (out_valid && out_ready) begin
        n_xfer++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_char: got %02h, required none", out_char);
        end else begin
          exp_ch = exp_q.pop_front();
          check("char", out_char, exp_ch);
        end
      end
      hold_pend = out_valid && !out_ready;
      hold_ch   = out_char;
    end
  end

  task automatic push_str(input string s);
    for (int k = 0; k < s.len(); k++) exp_q.push_back(s[k]);
  endtask

  task automatic do_call(input logic [31:0] c, input logic [31:0] a);
    @(posedge clk); #1;
    v0 = c;
    a0 = a;
    syscall = 1'b1;
    @(posedge clk); #1;
    syscall = 1'b0;
    v0 = $urandom;
    a0 = $urandom;
  endtask

  task automatic wait_idle(input string name);
    int k;
    for (k = 0; k < 500; k++) begin
      @(negedge clk);
      if (!stall) break;
    end
    if (k == 500) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: stall still 1 after 500 cycles, required 0", name);
    end
    #1;
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_char"}, out_char, 0);
    check({tag, "_stall"}, stall, 0);
    check({tag, "_halt"}, halt, 0);
`ifdef SYSCALL_STRLEN_LIMIT_EN
    check({tag, "_str_err"}, str_err, 0);
`endif
  endtask

  typedef struct {
    logic [31:0] v0;
    logic [31:0] a0;
    string       chars;
    int          stalls;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

  task automatic set_vec(input int i, input logic [31:0] c,
                         input logic [31:0] a, input string s,
                         input int st);
    tbl[i].v0     = c;
    tbl[i].a0     = a;
    tbl[i].chars  = s;
    tbl[i].stalls = st;
  endtask

  initial begin
    int s0;
    int q0;
    int x0;
    for (int i = 0; i < 512; i++) mem[i] = 8'h00;
    mem[9'h100] = 8'h48;
    mem[9'h101] = 8'h69;
    mem[9'h1FF] = 8'h58;
    mem[9'h000] = 8'h59;
    for (int i = 0; i < 10; i++) mem[9'h040 + 9'(i)] = 8'h41 + 8'(i);

    set_vec(0, 32'd1,  32'hDEADBEEF, "deadbeef", 10);
    set_vec(1, 32'd1,  32'h0A5F09C3, "0a5f09c3", 10);
    set_vec(2, 32'd1,  32'hFFFFFFFF, "ffffffff", 10);
    set_vec(3, 32'd11, 32'h12345641, "A", 3);
    set_vec(4, 32'd11, 32'h0000007E, "~", 3);
    set_vec(5, 32'd7,  32'h00000000, "", 2);
    set_vec(6, 32'd0,  32'h00000100, "", 2);
    set_vec(7, 32'd4,  32'h00000100, "Hi", 7);
    set_vec(8, 32'd4,  32'h00000180, "", 3);
    set_vec(9, 32'd4,  32'hFFFFFFFF, "XY", 7);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_rst("rst");
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      s0 = stall_cnt;
      q0 = memreq_cnt;
      x0 = n_xfer;
      addr_log.delete();
      push_str(tbl[i].chars);
      do_call(tbl[i].v0, tbl[i].a0);
      wait_idle("vec");
      check("vec_stall_cycles", stall_cnt - s0, tbl[i].stalls);
      check("vec_xfer", n_xfer - x0, tbl[i].chars.len());
      check("vec_qempty", exp_q.size(), 0);
      if (tbl[i].v0 == 32'd4) begin
        check("vec_nfetch", addr_log.size(), tbl[i].chars.len() + 1);
        for (int k = 0; k < addr_log.size(); k++)
          check("vec_addr", addr_log[k], tbl[i].a0 + 32'(k));
      end else begin
        check("vec_noreq", memreq_cnt - q0, 0);
      end
    end

    // slow memory and a console that accepts every other cycle
    mem_lat = 3;
    tog = 1'b1;
    addr_log.delete();
    x0 = n_xfer;
    push_str("Hi");
    do_call(32'd4, 32'h100);
    wait_idle("hi");
    tog = 1'b0;
    mem_lat = 0;
    check("hi_xfer", n_xfer - x0, 2);
    check("hi_qempty", exp_q.size(), 0);
    check("hi_nfetch", addr_log.size(), 3);
    for (int k = 0; k < addr_log.size() && k < 3; k++)
      check("hi_addr", addr_log[k], 32'h100 + 32'(k));

    // reset while print_int sits at digit 3
    x0 = n_xfer;
    push_str("89abcdef");
    do_call(32'd1, 32'h89ABCDEF);
    for (int k = 0; k < 100 && n_xfer < x0 + 3; k++) @(negedge clk);
    check("mid_xfer", n_xfer - x0, 3);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_rst("mid_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    exp_q.delete();
    s0 = stall_cnt;
    push_str("Z");
    do_call(32'd11, 32'h0000005A);
    wait_idle("post_rst");
    check("post_rst_stall", stall_cnt - s0, 3);
    check("post_rst_qempty", exp_q.size(), 0);

`ifdef SYSCALL_STRLEN_LIMIT_EN
    s0 = stall_cnt;
    x0 = n_xfer;
    push_str("ABCD");
    do_call(32'd4, 32'h40);
    wait_idle("lim");
    check("lim_xfer", n_xfer - x0, 4);
    check("lim_qempty", exp_q.size(), 0);
    check("lim_str_err", str_err, 1);
    check("lim_stall_cycles", stall_cnt - s0, 10);
    check("lim_stall", stall, 0);
    check("lim_halt", halt, 0);
`endif

    do_call(32'd10, 32'h0);
    for (int k = 0; k < 50; k++) begin
      @(posedge clk); #1;
      syscall = (k % 7 == 3);
      v0 = 32'd1;
      a0 = $urandom;
      @(negedge clk);
      check("halt_held", halt, 1);
      check("halt_stall", stall, 1);
    end
    @(posedge clk); #1;
    syscall = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_rst("exit_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
